regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2).
REQ-003 SHALL have parameter AW, default 5, address width, equal to log2(NREG).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rs1_addr / rs2_addr  input  AW  read port addresses.
REQ-007 SHALL have port rs1_data / rs2_data  output  XLEN  read data, combinational.
REQ-008 SHALL have port rs1_busy / rs2_busy  output  1  source has a pending producer.
REQ-009 SHALL have port rd_addr  input  AW  writeback address.
REQ-010 SHALL have port w_data  input  XLEN  writeback data.
REQ-011 SHALL have port w_en  input  1  writeback strobe.
REQ-012 SHALL have port issue_en  input  1  mark issue_addr busy.
REQ-013 SHALL have port issue_addr  input  AW  destination of the issuing instruction.
REQ-014 SHALL have port flush  input  1  clear all busy bits.
REQ-015 SHALL have port ready  output  1  initialisation done; accepting traffic.
REQ-016 SHALL have port busy_cnt  output  AW+1  number of busy registers.

Function
REQ-017 SHALL hold NREG x XLEN storage plus an NREG-bit busy vector; register 0 reads as zero and is never written or marked busy.
REQ-018 SHALL implement FSM states CLEAR and RUN; CLEAR writes zero to entry cnt each cycle, cnt 0..NREG-1, then enters RUN on the cycle after cnt = NREG-1 (NREG cycles total).
REQ-019 SHALL drive ready = 1 only in RUN; in CLEAR, w_en, issue_en and flush are ignored and rs*_data/rs*_busy read 0.
REQ-020 SHALL, in RUN, write w_data to rd_addr on the clock edge when w_en = 1 and rd_addr != 0.
REQ-021 SHALL bypass: rsN_data = w_data when w_en = 1, rd_addr = rsN_addr and rsN_addr != 0; otherwise stored value; rsN_addr = 0 gives 0.
REQ-022 SHALL set busy[issue_addr] at the edge when issue_en = 1 and issue_addr != 0.
REQ-023 SHALL clear busy[rd_addr] at the edge when w_en = 1.
REQ-024 SHALL give set priority over clear when issue and writeback target the same address in one cycle (busy stays 1).
REQ-025 SHALL clear the whole busy vector when flush = 1, overriding same-cycle issue_en and w_en busy updates; the w_en data write still occurs.
REQ-026 SHALL compute rsN_busy = busy[rsN_addr] & ~(w_en & rd_addr = rsN_addr); same-cycle issue does not affect it; address 0 gives 0.
REQ-027 SHALL keep busy_cnt registered and equal to popcount of the busy vector after each edge; range 0..NREG-1; it never wraps.
REQ-028 SHALL permit issue to an already-busy address (no change, no count increment) and writeback to a non-busy address (no count decrement).

Reset
REQ-029 SHALL on rst_n = 0, immediately and regardless of clock: state = CLEAR, cnt = 0, busy vector = 0, busy_cnt = 0, ready = 0.
REQ-030 SHALL, on reset asserted mid-CLEAR or mid-RUN, restart the full NREG-cycle clear after rst_n deasserts; storage contents are not relied upon until ready = 1.

Verification
REQ-031 Reset release, count cycles -> ready rises exactly 32 cycles later; all 32 registers read 0.
REQ-032 RUN: w_en=1, rd=5, w_data=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF combinationally; next cycle without w_en still 0xDEADBEEF.
REQ-033 Write rd=0, data=0x12345678 -> rs1_addr=0 reads 0; busy[0] never set, busy_cnt unchanged.
REQ-034 Issue 3, then 7 -> busy_cnt=2, rs1_busy(3)=1; writeback rd=3 -> rs1_busy(3)=0 that cycle, busy_cnt=1 next; issue 7 plus writeback 7 same cycle -> busy stays 1, busy_cnt=1.
REQ-035 Busy {3,7,9}, flush with issue_en to 4 same cycle -> busy_cnt=0, rs1_busy(4)=0 next cycle.
REQ-036 rst_n pulsed low mid-RUN with busy_cnt=4 -> ready=0 and busy_cnt=0 asynchronously; ready returns after 32 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard, write-through
// bypass and a post-reset clearing sequence that zeroes every entry.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic            w_en,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  input  logic            flush,
  output logic            ready,
  output logic [AW:0]     busy_cnt
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  // Sequencer: walk cnt over every entry once, then run until the next reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     ;
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the CLEAR sweep zeroes it instead,
  // which keeps it mappable onto plain RAM without a reset net per bit.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (w_en && (rd_addr != '0)) begin
      mem[rd_addr] <= w_data;
    end
  end

  // Flush wins over everything; within a cycle, issue (set) wins over writeback (clear).
  // NOTE: busy_next is defaulted first so no path through the block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (w_en) begin
        busy_next[rd_addr] = 1'b0;
      end
      if (issue_en && (issue_addr != '0)) begin
        busy_next[issue_addr] = 1'b1;
      end
    end
  end

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (state == RUN) begin
      busy     <= busy_next;
      busy_cnt <= popcount(busy_next);
    end
  end

  // Read side: x0 is hard-wired zero and a same-cycle writeback is forwarded.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (ready) begin
      if (rs1_addr != '0) begin
        rs1_data = (w_en && (rd_addr == rs1_addr)) ? w_data : mem[rs1_addr];
        rs1_busy = busy[rs1_addr] & ~(w_en & (rd_addr == rs1_addr));
      end
      if (rs2_addr != '0) begin
        rs2_data = (w_en && (rd_addr == rs2_addr)) ? w_data : mem[rs2_addr];
        rs2_busy = busy[rs2_addr] & ~(w_en & (rd_addr == rs2_addr));
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic compared every cycle against a behavioural register/scoreboard model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, issue_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, w_data;
  logic            rs1_busy, rs2_busy, w_en, issue_en, flush, ready;
  logic [AW:0]     busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .ready(ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register values, busy set, and clear-phase progress.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b0;
      m_clr   = 0;
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == NREG) m_ready = 1'b1;
    end else begin
      if (w_en && rd_addr != 0) m_mem[rd_addr] = w_data;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        if (w_en) m_busy[rd_addr] = 1'b0;
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (w_en && rd_addr == a) return w_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return 1'b0;
    return m_busy[a] && !(w_en && rd_addr == a);
  endfunction

  always @(negedge clk) begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    check("ready",    64'(ready),    64'(m_ready));
    check("rs1_data", 64'(rs1_data), 64'(exp_data(rs1_addr)));
    check("rs2_data", 64'(rs2_data), 64'(exp_data(rs2_addr)));
    check("rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1_addr)));
    check("rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2_addr)));
    check("busy_cnt", 64'(busy_cnt), 64'(cnt));
  end

  task automatic set_in(input bit we, input logic [AW-1:0] rd, input logic [XLEN-1:0] wd,
                        input bit ie, input logic [AW-1:0] ia, input bit fl,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    w_en = we; rd_addr = rd; w_data = wd;
    issue_en = ie; issue_addr = ia; flush = fl;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic rand_in();
    logic [AW-1:0] rd;
    rd = AW'($urandom_range(0, NREG - 1));
    set_in($urandom_range(0, 1) == 1, rd, $urandom,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, NREG - 1)),
           $urandom_range(0, 15) == 0,
           ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1)),
           ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1)));
  endtask

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic cyc(input bit we, input logic [AW-1:0] rd, input logic [XLEN-1:0] wd,
                     input bit ie, input logic [AW-1:0] ia, input bit fl,
                     input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(posedge clk); #1;
    set_in(we, rd, wd, ie, ia, fl, a1, a2);
    @(negedge clk); #1;
  endtask

  // Counts rising edges until ready, with ignored random traffic meanwhile.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!ready) rand_in();
    end while (!ready && n < 100);
    check(name, 64'(n), 64'd32);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #23;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy_cnt", 64'(busy_cnt), 64'd0);
    rst_n = 1'b1;
    wait_ready("ready_latency_init");

    for (int i = 0; i < NREG / 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0, AW'(2 * i), AW'(2 * i + 1));
      check("cleared_rs1", 64'(rs1_data), 64'd0);
      check("cleared_rs2", 64'(rs2_data), 64'd0);
    end

    // Bypass and persistence
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    check("bypass_rs1", 64'(rs1_data), 64'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 5, 5);
    check("stored_rs1", 64'(rs1_data), 64'hDEADBEEF);
    check("stored_rs2", 64'(rs2_data), 64'hDEADBEEF);

    // x0 is never written
    cyc(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    check("x0_bypass", 64'(rs1_data), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_read", 64'(rs1_data), 64'd0);
    check("x0_busy_cnt", 64'(busy_cnt), 64'd0);

    // Scoreboard set/clear and set-over-clear priority
    cyc(0, 0, 0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 3, 7);
    check("cnt_after_3_7", 64'(busy_cnt), 64'd2);
    check("busy3", 64'(rs1_busy), 64'd1);
    check("busy7", 64'(rs2_busy), 64'd1);
    cyc(1, 3, 32'h33, 0, 0, 0, 3, 0);
    check("busy3_wb_same_cycle", 64'(rs1_busy), 64'd0);
    cyc(1, 7, 32'h77, 1, 7, 0, 7, 3);
    check("cnt_after_wb3", 64'(busy_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 7, 0);
    check("busy7_kept", 64'(rs1_busy), 64'd1);
    check("cnt_set_wins", 64'(busy_cnt), 64'd1);

    // Flush overrides a same-cycle issue
    cyc(0, 0, 0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 1, 4, 0);
    check("cnt_before_flush", 64'(busy_cnt), 64'd3);
    cyc(0, 0, 0, 0, 0, 0, 4, 9);
    check("cnt_after_flush", 64'(busy_cnt), 64'd0);
    check("busy4_after_flush", 64'(rs1_busy), 64'd0);
    check("busy9_after_flush", 64'(rs2_busy), 64'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      rand_in();
    end

    // Asynchronous reset mid-RUN with four busy registers
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, AW'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("cnt_before_reset", 64'(busy_cnt), 64'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_ready", 64'(ready), 64'd0);
    check("async_busy_cnt", 64'(busy_cnt), 64'd0);
    #10;
    rst_n = 1'b1;
    wait_ready("ready_latency_rerun");
    for (int i = 0; i < NREG / 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0, AW'(2 * i), AW'(2 * i + 1));
      check("recleared_rs1", 64'(rs1_data), 64'd0);
      check("recleared_rs2", 64'(rs2_data), 64'd0);
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
